// File: rtl/piano_pkg.sv
// Shared piano-path definitions: note/amplitude widths, note-code limits and the
// half-period table function used by the tone oscillators.
package piano_pkg;

   localparam int NOTE_W     = 6;
   localparam int AMP_W      = 4;
   localparam int CNT_W      = 20;
   localparam int ENV_W      = 21;
   localparam int LEVEL_W    = 6;
   localparam int PWM_W      = 6;
   localparam int NUM_TRACKS = 4;

   typedef logic [NOTE_W-1:0] note_t;
   typedef logic [AMP_W-1:0]  amp_t;

   localparam note_t NOTE_REST = 6'd0;
   localparam note_t NOTE_MAX  = 6'd48;
   localparam amp_t  AMP_FULL  = 4'd15;

   // What a channel does with its counter and phase in a given cycle
   typedef enum logic [1:0] {
      EV_COUNT,
      EV_WRAP,
      EV_RESTART,
      EV_SILENT
   } ch_event_e;

   function automatic logic is_playable(input note_t n);
      return (n != NOTE_REST) && (n <= NOTE_MAX);
   endfunction

   // Evaluated at elaboration only: round(clk / (2 * f(n))), f(1) = C3.
   function automatic logic [CNT_W-1:0] half_period(input int unsigned n,
                                                    input int unsigned clk_hz);
      real f;
      if (n == 0 || n > int'(NOTE_MAX)) return '0;
      f = 130.8128 * (2.0 ** ((real'(n) - 1.0) / 12.0));
      return CNT_W'($rtoi(real'(clk_hz) / (2.0 * f) + 0.5));
   endfunction

endpackage

// File: rtl/track_tone_mixer_if.sv
// Track-code inputs and speaker/busy outputs of the tone mixer; the track
// manager side drives the master modport, the mixer uses the slave modport.
interface track_tone_mixer_if;

   piano_pkg::note_t iTrack0;
   piano_pkg::note_t iTrack1;
   piano_pkg::note_t iTrack2;
   piano_pkg::note_t iTrack3;
   logic             oFpgaSpeaker;
   logic             oBusy;

   modport master (
      output iTrack0, iTrack1, iTrack2, iTrack3,
      input  oFpgaSpeaker, oBusy
   );

   modport slave (
      input  iTrack0, iTrack1, iTrack2, iTrack3,
      output oFpgaSpeaker, oBusy
   );

endinterface

// File: rtl/track_tone_mixer_channel.sv
// One square-wave voice: note register, change detect, half-period counter and
// phase. Decaying amplitude envelope is built only with PIANO_ENVELOPE_EN.
module tone_channel
   import piano_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned ENV_STEP_CYCLES = 1_562_500
) (
   input  logic  clk,
   input  logic  rst_n,
   input  note_t note_in,
   output logic  phase,
   output amp_t  amp,
   output logic  playable
);

   note_t             note_q, note_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              phase_q, phase_d;
   logic              note_change;
   logic              note_live;
   ch_event_e         ev;

   logic [CNT_W-1:0]  half_tbl [2**NOTE_W];

   genvar gi;
   generate
      for (gi = 0; gi < 2**NOTE_W; gi++) begin : g_tbl
         localparam logic [CNT_W-1:0] HALF = half_period(gi, CLK_HZ);
         assign half_tbl[gi] = HALF;
      end
   endgenerate

   assign note_change = (note_in != note_q);
   assign note_live   = is_playable(note_q);

   // A code change outranks a wrap, so a new note always starts from phase 0
   always_comb begin
      ev = EV_COUNT;
      if (note_change)
         ev = EV_RESTART;
      else if (!note_live)
         ev = EV_SILENT;
      else if (cnt_q == half_tbl[note_q] - CNT_W'(1))
         ev = EV_WRAP;

      note_d  = note_in;
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
      case (ev)
         EV_RESTART, EV_SILENT: begin
            cnt_d   = '0;
            phase_d = 1'b0;
         end
         EV_WRAP: begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_q  <= NOTE_REST;
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         note_q  <= note_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

`ifdef PIANO_ENVELOPE_EN
   logic [ENV_W-1:0] env_q, env_d;
   amp_t             amp_q, amp_d;
   logic             env_tick;

   assign env_tick = (env_q == ENV_W'(ENV_STEP_CYCLES - 1));

   always_comb begin
      env_d = env_q;
      amp_d = amp_q;
      if (note_change) begin
         env_d = '0;
         amp_d = is_playable(note_in) ? AMP_FULL : amp_t'(0);
      end else if (note_live) begin
         if (env_tick) begin
            env_d = '0;
            amp_d = (amp_q != '0) ? amp_q - amp_t'(1) : amp_t'(0);
         end else begin
            env_d = env_q + ENV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         env_q <= '0;
         amp_q <= '0;
      end else begin
         env_q <= env_d;
         amp_q <= amp_d;
      end
   end

   assign amp = amp_q;
`else
   assign amp = note_live ? AMP_FULL : amp_t'(0);
`endif

   assign phase    = phase_q;
   assign playable = note_live;

endmodule

// File: rtl/track_tone_mixer.sv
// Four-voice square-wave mixer driving a 64-step PWM speaker pin.
// Optional per-voice decay envelope: define PIANO_ENVELOPE_EN.
module track_tone_mixer
   import piano_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned ENV_STEP_CYCLES = 1_562_500
) (
   input  logic                iFpgaClock,
   input  logic                iFpgaResetN,
   track_tone_mixer_if.slave   bus
);

   note_t                  track_in [NUM_TRACKS];
   logic [NUM_TRACKS-1:0]  phase_vec;
   logic [NUM_TRACKS-1:0]  live_vec;
   amp_t                   amp_vec  [NUM_TRACKS];

   logic [LEVEL_W-1:0]     level;
   logic [PWM_W-1:0]       pwm_q, pwm_d;
   logic                   spk_q, spk_d;
   logic                   busy_q, busy_d;

   assign track_in[0] = bus.iTrack0;
   assign track_in[1] = bus.iTrack1;
   assign track_in[2] = bus.iTrack2;
   assign track_in[3] = bus.iTrack3;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TRACKS; gi++) begin : g_ch
         tone_channel #(
            .CLK_HZ          (CLK_HZ),
            .ENV_STEP_CYCLES (ENV_STEP_CYCLES)
         ) u_ch (
            .clk      (iFpgaClock),
            .rst_n    (iFpgaResetN),
            .note_in  (track_in[gi]),
            .phase    (phase_vec[gi]),
            .amp      (amp_vec[gi]),
            .playable (live_vec[gi])
         );
      end
   endgenerate

   // Four 4-bit amplitudes sum to at most 60, which fits the 6-bit carrier range
   always_comb begin
      level = '0;
      for (int k = 0; k < NUM_TRACKS; k++)
         level = level + (phase_vec[k] ? LEVEL_W'(amp_vec[k]) : LEVEL_W'(0));
   end

   always_comb begin
      pwm_d  = pwm_q + PWM_W'(1);
      spk_d  = (pwm_q < level);
      busy_d = |live_vec;
   end

   always_ff @(posedge iFpgaClock or negedge iFpgaResetN) begin
      if (!iFpgaResetN) begin
         pwm_q  <= '0;
         spk_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         pwm_q  <= pwm_d;
         spk_q  <= spk_d;
         busy_q <= busy_d;
      end
   end

   assign bus.oFpgaSpeaker = spk_q;
   assign bus.oBusy        = busy_q;

endmodule

// File: tb/tb_track_tone_mixer.sv
// Scoreboard bench for track_tone_mixer at a 1 MHz table clock; expected phase/busy
// events are queued by the stimulus and matched by an independent monitor.
module tb_track_tone_mixer;
   import piano_pkg::*;

   localparam int unsigned TB_CLK_HZ = 1_000_000;
   // round(1e6 / (2 * f)) for C3, A4, A5 and B6
   localparam int H1  = 3822;
   localparam int H22 = 1136;
   localparam int H34 = 568;
   localparam int H48 = 253;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   track_tone_mixer_if bus ();

   track_tone_mixer #(
      .CLK_HZ          (TB_CLK_HZ),
      .ENV_STEP_CYCLES (10)
   ) dut (
      .iFpgaClock  (clk),
      .iFpgaResetN (rst_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0] phase_now;
   assign phase_now = {dut.g_ch[3].u_ch.phase_q, dut.g_ch[2].u_ch.phase_q,
                       dut.g_ch[1].u_ch.phase_q, dut.g_ch[0].u_ch.phase_q};

   typedef struct {
      int         cyc;
      logic [3:0] phase;
      logic       busy;
   } ev_t;

   ev_t exp_q [$];
   int  n_tests = 0;
   int  n_fail  = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic push(input int c, input logic [3:0] ph, input logic b);
      exp_q.push_back('{cyc: c, phase: ph, busy: b});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic set_tracks(input int a, input int b, input int c, input int d);
      bus.iTrack0 = note_t'(a);
      bus.iTrack1 = note_t'(b);
      bus.iTrack2 = note_t'(c);
      bus.iTrack3 = note_t'(d);
      $display("[TB] cycle %0d tracks <= %0d %0d %0d %0d", cyc, a, b, c, d);
   endtask

   task automatic duty(input string name, input int exp);
      int hi;
      hi = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         hi += int'(bus.oFpgaSpeaker);
      end
      $display("[TB] cycle %0d %s: %0d/64 high", cyc, name, hi);
      check(name, hi, exp);
   endtask

   // Monitor: every change of the phase vector or busy flag is one transaction
   initial begin
      logic [3:0] prev_ph;
      logic       prev_busy;
      ev_t        e;
      prev_ph   = '0;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (phase_now !== prev_ph || bus.oBusy !== prev_busy) begin
            $display("[TB] cycle %0d event phase=%b busy=%b", cyc, phase_now, bus.oBusy);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_event: phase %b busy %b at cycle %0d, nothing queued",
                        phase_now, bus.oBusy, cyc);
            end else begin
               e = exp_q.pop_front();
               check("ev_cycle", cyc, e.cyc);
               check("ev_phase", int'(phase_now), int'(e.phase));
               check("ev_busy", int'(bus.oBusy), int'(e.busy));
            end
            prev_ph   = phase_now;
            prev_busy = bus.oBusy;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench still running at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, t1, j, k, m, m2, p, q, s, u, w;
      set_tracks(22, 22, 22, 22);
      repeat (5) step();
      check("reset_speaker", int'(bus.oFpgaSpeaker), 0);
      check("reset_busy", int'(bus.oBusy), 0);

      // Release: busy two edges later, all four A4 voices toggle together
      r = cyc;
      rst_n = 1'b1;
      push(r + 2, 4'b0000, 1'b1);
      t1 = r + 1 + H22;
      push(t1, 4'b1111, 1'b1);

      run_to(t1 + 10);
      j = cyc;
      set_tracks(22, 0, 0, 0);
      push(j + 1, 4'b0001, 1'b1);
      push(t1 + H22, 4'b0000, 1'b1);
      push(t1 + 2 * H22, 4'b0001, 1'b1);
`ifndef PIANO_ENVELOPE_EN
      run_to(t1 + H22 + 100);
      duty("duty_a4_low", 0);
      run_to(t1 + 2 * H22 + 100);
      duty("duty_a4_high", 15);
`endif

      // Retune while phase is high: immediate clear, then A5 half period
      run_to(t1 + 2 * H22 + 300);
      k = cyc;
      set_tracks(34, 0, 0, 0);
      push(k + 1, 4'b0000, 1'b1);
      push(k + 1 + H34, 4'b0001, 1'b1);

      run_to(k + 1 + H34 + 5);
      w = 0;
      while (bus.oFpgaSpeaker !== 1'b1 && w < 64) begin
         step();
         w++;
      end
      check("speaker_high_before_reset", int'(bus.oFpgaSpeaker), 1);
      m = cyc;
      rst_n = 1'b0;
      push(m, 4'b0000, 1'b0);
      #1;
      check("async_reset_speaker", int'(bus.oFpgaSpeaker), 0);
      check("async_reset_busy", int'(bus.oBusy), 0);
      set_tracks(22, 0, 0, 0);
      repeat (3) step();
      m2 = cyc;
      rst_n = 1'b1;
      push(m2 + 2, 4'b0000, 1'b1);
      push(m2 + 1 + H22, 4'b0001, 1'b1);

      // Four C3 voices in lockstep, then drop one to an out-of-range code
      run_to(m2 + 1 + H22 + 5);
      p = cyc;
      set_tracks(1, 1, 1, 1);
      push(p + 1, 4'b0000, 1'b1);
      push(p + 1 + H1, 4'b1111, 1'b1);
      run_to(p + 1 + H1 + 10);
`ifndef PIANO_ENVELOPE_EN
      duty("duty_four_voices", 60);
`endif
      q = cyc;
      set_tracks(1, 1, 63, 1);
      push(q + 1, 4'b1011, 1'b1);
      step();
      step();
`ifndef PIANO_ENVELOPE_EN
      duty("duty_three_voices", 45);
`endif
      check("busy_with_code63", int'(bus.oBusy), 1);

      // Boundary codes: 48 plays, 49 is a rest
      s = cyc;
      set_tracks(48, 49, 0, 0);
      push(s + 1, 4'b0000, 1'b1);
      push(s + 1 + H48, 4'b0001, 1'b1);
      run_to(s + 1 + H48 + 10);
      u = cyc;
      set_tracks(0, 49, 0, 0);
      push(u + 1, 4'b0000, 1'b1);
      push(u + 2, 4'b0000, 1'b0);
      run_to(u + 20);
      check("busy_code49_only", int'(bus.oBusy), 0);

`ifdef PIANO_ENVELOPE_EN
      begin
         int v, x, y, z;
         v = cyc;
         set_tracks(48, 49, 0, 0);
         push(v + 2, 4'b0000, 1'b1);
         for (int i = 0; i <= 16; i++) begin
            run_to(v + 1 + 10 * i);
            check("env_amp", int'(dut.g_ch[0].u_ch.amp_q), (i < 15) ? 15 - i : 0);
         end
         x = cyc;
         set_tracks(0, 49, 0, 0);
         push(x + 2, 4'b0000, 1'b0);
         run_to(x + 5);
         y = cyc;
         set_tracks(48, 49, 0, 0);
         push(y + 2, 4'b0000, 1'b1);
         run_to(y + 1);
         check("env_reonset_amp", int'(dut.g_ch[0].u_ch.amp_q), 15);
         run_to(y + 10);
         z = cyc;
         set_tracks(0, 49, 0, 0);
         push(z + 2, 4'b0000, 1'b0);
         run_to(z + 10);
      end
`endif

      run_to(cyc + 20);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
